// File: rtl/food_array.sv
// rtl/food_array.sv - multi-slot food manager: LFSR respawn, head hit detection, grow/win, pixel draw sequencer
// Slot state is sampled at the start of each cycle, so a slot freed by a hit can respawn no earlier than the next edge.
module food_array #(
   parameter int          NUM_FOOD  = 4,
   parameter int          FOOD_SIZE = 2,
   parameter int          X_MAX     = 160,
   parameter int          Y_MAX     = 120,
   parameter int          GROW_INIT = 6,
   parameter int          GROW_MAX  = 200,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  h_x,
   input  logic [6:0]  h_y,
   input  logic        en,
   output logic [7:0]  out_x,
   output logic [6:0]  out_y,
   output logic [2:0]  f_colour,
   output logic        out_valid,
   output logic        frame_done,
   output logic        eat,
   output logic [10:0] grow,
   output logic        win
);

   localparam int            SW       = (NUM_FOOD > 1) ? $clog2(NUM_FOOD) : 1;
   localparam int            PW       = (FOOD_SIZE > 1) ? $clog2(FOOD_SIZE) : 1;
   localparam logic [8:0]    CX_MAX   = 9'(X_MAX - FOOD_SIZE);
   localparam logic [7:0]    CY_MAX   = 8'(Y_MAX - FOOD_SIZE);
   localparam logic [8:0]    SPAN_X   = 9'(FOOD_SIZE - 1);
   localparam logic [7:0]    SPAN_Y   = 8'(FOOD_SIZE - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(FOOD_SIZE - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(NUM_FOOD - 1);
   localparam logic [10:0]   G_INIT   = 11'(GROW_INIT);
   localparam logic [10:0]   G_MAX    = 11'(GROW_MAX);
   localparam logic          WIN_INIT = (GROW_INIT >= GROW_MAX);

   logic [15:0]         lfsr_q, lfsr_d;
   logic [NUM_FOOD-1:0] alive_q, alive_d;
   logic [7:0]          x_q [NUM_FOOD];
   logic [6:0]          y_q [NUM_FOOD];
   logic [2:0]          c_q [NUM_FOOD];
   logic [10:0]         grow_q, grow_d;
   logic                win_q, win_d;
   logic                eat_q, eat_d;
   logic [SW-1:0]       s_q, s_d;
   logic [PW-1:0]       px_q, px_d, py_q, py_d;
   logic [7:0]          ox_q, ox_d;
   logic [6:0]          oy_q, oy_d;
   logic [2:0]          oc_q, oc_d;
   logic                ov_q, ov_d, fd_q, fd_d;

   logic [7:0]    cx;
   logic [6:0]    cy;
   logic          legal, spawn, hit_any, dead_any, adv;
   logic [SW-1:0] hit_idx, spawn_idx;

   // Widened compares keep x+FOOD_SIZE-1 from wrapping near the playfield edge.
   function automatic logic covers(input logic [7:0] ox, input logic [6:0] oy,
                                   input logic [7:0] hx, input logic [6:0] hy);
      return ({1'b0, hx} >= {1'b0, ox}) && ({1'b0, hx} <= {1'b0, ox} + SPAN_X) &&
             ({1'b0, hy} >= {1'b0, oy}) && ({1'b0, hy} <= {1'b0, oy} + SPAN_Y);
   endfunction

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      cx     = lfsr_q[7:0];
      cy     = lfsr_q[14:8];
      legal  = ({1'b0, cx} <= CX_MAX) && ({1'b0, cy} <= CY_MAX) && !covers(cx, cy, h_x, h_y);

      hit_any   = 1'b0;
      hit_idx   = '0;
      dead_any  = 1'b0;
      spawn_idx = '0;
      // Descending scan so the lowest index is the one left standing.
      for (int i = NUM_FOOD - 1; i >= 0; i--) begin
         if (alive_q[i] && covers(x_q[i], y_q[i], h_x, h_y)) begin
            hit_any = 1'b1;
            hit_idx = SW'(i);
         end
         if (!alive_q[i]) begin
            dead_any  = 1'b1;
            spawn_idx = SW'(i);
         end
      end

      eat_d   = !win_q && hit_any;
      spawn   = !win_q && legal && dead_any;
      alive_d = alive_q;
      if (eat_d) alive_d[hit_idx] = 1'b0;
      if (spawn) alive_d[spawn_idx] = 1'b1;

      grow_d = grow_q;
      win_d  = win_q;
      if (eat_d && grow_q != G_MAX) begin
         grow_d = grow_q + 11'd1;
         if (grow_q + 11'd1 == G_MAX) win_d = 1'b1;
      end
   end

   always_comb begin
      s_d  = s_q;
      px_d = px_q;
      py_d = py_q;
      ox_d = ox_q;
      oy_d = oy_q;
      oc_d = oc_q;
      ov_d = 1'b0;
      fd_d = 1'b0;
      adv  = 1'b0;
      if (en) begin
         if (alive_q[s_q]) begin
            ox_d = x_q[s_q] + 8'(px_q);
            oy_d = y_q[s_q] + 7'(py_q);
            oc_d = c_q[s_q];
            ov_d = 1'b1;
            if (px_q == P_LAST) begin
               px_d = '0;
               if (py_q == P_LAST) begin
                  py_d = '0;
                  adv  = 1'b1;
               end else begin
                  py_d = py_q + PW'(1);
               end
            end else begin
               px_d = px_q + PW'(1);
            end
         end else begin
            // Dead slot (possibly eaten mid-draw) costs exactly one strobe.
            px_d = '0;
            py_d = '0;
            adv  = 1'b1;
         end
         if (adv) begin
            if (s_q == S_LAST) begin
               s_d  = '0;
               fd_d = 1'b1;
            end else begin
               s_d = s_q + SW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q  <= LFSR_SEED;
         alive_q <= '0;
         for (int i = 0; i < NUM_FOOD; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            c_q[i] <= '0;
         end
         grow_q <= G_INIT;
         win_q  <= WIN_INIT;
         eat_q  <= 1'b0;
         s_q    <= '0;
         px_q   <= '0;
         py_q   <= '0;
         ox_q   <= '0;
         oy_q   <= '0;
         oc_q   <= '0;
         ov_q   <= 1'b0;
         fd_q   <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         alive_q <= alive_d;
         if (spawn) begin
            x_q[spawn_idx] <= cx;
            y_q[spawn_idx] <= cy;
            c_q[spawn_idx] <= {lfsr_q[1:0], 1'b1};
         end
         grow_q <= grow_d;
         win_q  <= win_d;
         eat_q  <= eat_d;
         s_q    <= s_d;
         px_q   <= px_d;
         py_q   <= py_d;
         ox_q   <= ox_d;
         oy_q   <= oy_d;
         oc_q   <= oc_d;
         ov_q   <= ov_d;
         fd_q   <= fd_d;
      end
   end

   assign out_x      = ox_q;
   assign out_y      = oy_q;
   assign f_colour   = oc_q;
   assign out_valid  = ov_q;
   assign frame_done = fd_q;
   assign eat        = eat_q;
   assign grow       = grow_q;
   assign win        = win_q;

endmodule

// File: tb/tb_food_array.sv
// tb/tb_food_array.sv - directed vector bench for food_array (2 slots, 2x2 food, GROW_MAX 8, seed 16'h140A)
module tb_food_array;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  h_x;
   logic [6:0]  h_y;
   logic        en;
   logic [7:0]  out_x;
   logic [6:0]  out_y;
   logic [2:0]  f_colour;
   logic        out_valid, frame_done, eat, win;
   logic [10:0] grow;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   food_array #(
      .NUM_FOOD(2), .FOOD_SIZE(2), .X_MAX(160), .Y_MAX(120),
      .GROW_INIT(6), .GROW_MAX(8), .LFSR_SEED(16'h140A)
   ) dut (
      .clk(clk), .rst(rst), .h_x(h_x), .h_y(h_y), .en(en),
      .out_x(out_x), .out_y(out_y), .f_colour(f_colour), .out_valid(out_valid),
      .frame_done(frame_done), .eat(eat), .grow(grow), .win(win)
   );

   typedef struct {
      logic        en;
      logic [7:0]  hx;
      logic [6:0]  hy;
      logic        v;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [2:0]  c;
      logic        fd;
      logic        eat;
      logic [10:0] g;
      logic        w;
   } vec_t;

   vec_t t1 [30];
   vec_t t2 [12];
   vec_t rv;

   function automatic vec_t mk(int e, int hx, int hy, int v, int x, int y, int c,
                               int fd, int et, int g, int w);
      vec_t r;
      r.en = e[0];   r.hx = 8'(hx); r.hy = 7'(hy);
      r.v  = v[0];   r.x  = 8'(x);  r.y  = 7'(y);  r.c = 3'(c);
      r.fd = fd[0];  r.eat = et[0]; r.g = 11'(g);  r.w = w[0];
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s[%0d]: got %0d, want %0d", nm, idx, act, exp);
      end
   endtask

   task automatic check_outs(string tag, int idx, vec_t v);
      n_vec++;
      chk({tag, ".out_valid"},  idx, 32'(out_valid),  32'(v.v));
      chk({tag, ".out_x"},      idx, 32'(out_x),      32'(v.x));
      chk({tag, ".out_y"},      idx, 32'(out_y),      32'(v.y));
      chk({tag, ".f_colour"},   idx, 32'(f_colour),   32'(v.c));
      chk({tag, ".frame_done"}, idx, 32'(frame_done), 32'(v.fd));
      chk({tag, ".eat"},        idx, 32'(eat),        32'(v.eat));
      chk({tag, ".grow"},       idx, 32'(grow),       32'(v.g));
      chk({tag, ".win"},        idx, 32'(win),        32'(v.w));
   endtask

   task automatic apply(string tag, int idx, vec_t v);
      en  = v.en;
      h_x = v.hx;
      h_y = v.hy;
      tick();
      check_outs(tag, idx, v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      h_x = 8'd159;
      h_y = 7'd119;
      rv  = mk(0, 159, 119, 0, 0, 0, 0, 0, 0, 6, 0);

      // Seed 140A spawns slot0 (10,20) col 5, then slot1 (5,10) col 3; head parked at (159,119).
      t1[0]  = mk(0, 159, 119, 0,   0,   0, 0, 0, 0, 6, 0);
      t1[1]  = mk(0, 159, 119, 0,   0,   0, 0, 0, 0, 6, 0);
      t1[2]  = mk(1, 159, 119, 1,  10,  20, 5, 0, 0, 6, 0);
      t1[3]  = mk(1, 159, 119, 1,  11,  20, 5, 0, 0, 6, 0);
      t1[4]  = mk(1, 159, 119, 1,  10,  21, 5, 0, 0, 6, 0);
      t1[5]  = mk(1, 159, 119, 1,  11,  21, 5, 0, 0, 6, 0);
      t1[6]  = mk(1, 159, 119, 1,   5,  10, 3, 0, 0, 6, 0);
      t1[7]  = mk(1, 159, 119, 1,   6,  10, 3, 0, 0, 6, 0);
      t1[8]  = mk(1, 159, 119, 1,   5,  11, 3, 0, 0, 6, 0);
      t1[9]  = mk(1, 159, 119, 1,   6,  11, 3, 1, 0, 6, 0);
      t1[10] = mk(0, 159, 119, 0,   6,  11, 3, 0, 0, 6, 0);
      t1[11] = mk(1, 159, 119, 1,  10,  20, 5, 0, 0, 6, 0);
      t1[12] = mk(1, 159, 119, 1,  11,  20, 5, 0, 0, 6, 0);
      t1[13] = mk(1, 159, 119, 1,  10,  21, 5, 0, 0, 6, 0);
      t1[14] = mk(1, 159, 119, 1,  11,  21, 5, 0, 0, 6, 0);
      t1[15] = mk(1, 159, 119, 1,   5,  10, 3, 0, 0, 6, 0);
      t1[16] = mk(1, 159, 119, 1,   6,  10, 3, 0, 0, 6, 0);
      // Slot1 eaten after its 2nd pixel: next strobe is a dead skip closing the frame.
      t1[17] = mk(0,   6,  11, 0,   6,  10, 3, 0, 1, 7, 0);
      t1[18] = mk(1, 159, 119, 0,   6,  10, 3, 1, 0, 7, 0);
      t1[19] = mk(1, 159, 119, 1,  10,  20, 5, 0, 0, 7, 0);
      // Slot1 respawned at (106,118) col 5 from LFSR 766A; eating slot0 reaches GROW_MAX.
      t1[20] = mk(0,  11,  21, 0,  10,  20, 5, 0, 1, 8, 1);
      t1[21] = mk(0, 159, 119, 0,  10,  20, 5, 0, 0, 8, 1);
      t1[22] = mk(1, 159, 119, 0,  10,  20, 5, 0, 0, 8, 1);
      t1[23] = mk(1, 159, 119, 1, 106, 118, 5, 0, 0, 8, 1);
      t1[24] = mk(1, 159, 119, 1, 107, 118, 5, 0, 0, 8, 1);
      t1[25] = mk(1, 159, 119, 1, 106, 119, 5, 0, 0, 8, 1);
      t1[26] = mk(1, 159, 119, 1, 107, 119, 5, 1, 0, 8, 1);
      t1[27] = mk(0, 107, 119, 0, 107, 119, 5, 0, 0, 8, 1);
      t1[28] = mk(1, 159, 119, 0, 107, 119, 5, 0, 0, 8, 1);
      t1[29] = mk(1, 159, 119, 1, 106, 118, 5, 0, 0, 8, 1);

      // After a fresh reset: eat slot0 with head held at (11,21); it respawns at (129,88) col 3 (LFSR 5881).
      t2[0]  = mk(0, 159, 119, 0,   0,   0, 0, 0, 0, 6, 0);
      t2[1]  = mk(0, 159, 119, 0,   0,   0, 0, 0, 0, 6, 0);
      t2[2]  = mk(0,  11,  21, 0,   0,   0, 0, 0, 1, 7, 0);
      t2[3]  = mk(0,  11,  21, 0,   0,   0, 0, 0, 0, 7, 0);
      t2[4]  = mk(1,  11,  21, 1, 129,  88, 3, 0, 0, 7, 0);
      t2[5]  = mk(1,  11,  21, 1, 130,  88, 3, 0, 0, 7, 0);
      t2[6]  = mk(1,  11,  21, 1, 129,  89, 3, 0, 0, 7, 0);
      t2[7]  = mk(1,  11,  21, 1, 130,  89, 3, 0, 0, 7, 0);
      t2[8]  = mk(1,  11,  21, 1,   5,  10, 3, 0, 0, 7, 0);
      t2[9]  = mk(1,  11,  21, 1,   6,  10, 3, 0, 0, 7, 0);
      t2[10] = mk(1,  11,  21, 1,   5,  11, 3, 0, 0, 7, 0);
      t2[11] = mk(1,  11,  21, 1,   6,  11, 3, 1, 0, 7, 0);

      repeat (3) tick();
      check_outs("reset", 0, rv);
      rst = 1'b1;

      for (int i = 0; i < 30; i++) apply("t1", i, t1[i]);

      // Asynchronous clear while a draw pixel is being presented.
      rst = 1'b0;
      #2;
      check_outs("areset_draw", 0, rv);
      en  = 1'b0;
      h_x = 8'd159;
      h_y = 7'd119;
      tick();
      rst = 1'b1;
      tick();
      tick();
      en  = 1'b1;
      h_x = 8'd11;
      h_y = 7'd21;
      tick();
      check_outs("eat_draw", 0, mk(1, 11, 21, 1, 10, 20, 5, 0, 1, 7, 0));
      // Asynchronous clear while eat is pulsing.
      rst = 1'b0;
      #2;
      check_outs("areset_eat", 0, rv);
      en  = 1'b0;
      h_x = 8'd159;
      h_y = 7'd119;
      tick();
      rst = 1'b1;

      for (int i = 0; i < 12; i++) apply("t2", i, t2[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
